usb_packet_fifo: RTL and testbench

Parametrised synchronous FIFO with packet commit/rollback, for USB endpoint buffering.
- Writer (USB RX side) pushes beats speculatively. A packet becomes visible to the reader only when its last beat is written without error.
- A packet can be aborted (bad CRC, PID error) or auto-dropped on overflow; the write pointer then rolls back.
- Reader side is valid/ready with a registered output stage. All DEPTH entries are usable.

---
 rtl/usb_packet_fifo_pkg.sv | 25 ++
 rtl/usb_packet_fifo_if.sv | 33 +++
 rtl/usb_defs.vh | 8 +
 rtl/usb_fifo_ram.sv | 30 +++
 rtl/usb_packet_fifo.sv | 130 +++++++++++++
 tb/tb_usb_packet_fifo.sv | 215 +++++++++++++++++++++
 6 files changed

// File: rtl/usb_packet_fifo_pkg.sv
// Shared types for usb_packet_fifo. USB_PACKET_FIFO_LAST_EN adds a packet-end
// flag alongside each stored beat.
package usb_packet_fifo_pkg;

`ifdef USB_PACKET_FIFO_LAST_EN
  localparam int LAST_BITS = 1;
`else
  localparam int LAST_BITS = 0;
`endif

  // Outcome of the writer-side inputs for one cycle.
  typedef enum logic [2:0] {
    WR_NONE,
    WR_PUSH,
    WR_OVERFLOW,
    WR_COMMIT,
    WR_DROP,
    WR_ABORT
  } wr_op_e;

  function automatic int ram_width(input int width);
    return width + LAST_BITS;
  endfunction

endpackage

// File: rtl/usb_packet_fifo_if.sv
// Writer/reader bundle for usb_packet_fifo. The master modport is the
// environment (USB RX writer plus consumer); the slave modport is the FIFO.
`include "usb_defs.vh"

interface usb_packet_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int AW = `CLOG2(DEPTH);

  logic [WIDTH-1:0] wr_data;
  logic             wr_strobe;
  logic             wr_last;
  logic             wr_abort;
  logic             wr_full;
  logic             pkt_dropped;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_last;
  logic [AW:0]      level;

  modport master (
    output wr_data, wr_strobe, wr_last, wr_abort, rd_ready,
    input  wr_full, pkt_dropped, rd_data, rd_valid, rd_last, level
  );

  modport slave (
    input  wr_data, wr_strobe, wr_last, wr_abort, rd_ready,
    output wr_full, pkt_dropped, rd_data, rd_valid, rd_last, level
  );

endinterface

// File: rtl/usb_defs.vh
// Shared definitions for the USB packet FIFO slice: ceiling-log2 helper for
// deriving address widths from entry counts.
`ifndef USB_DEFS_VH
`define USB_DEFS_VH

`define CLOG2(x) $clog2(x)

`endif

// File: rtl/usb_fifo_ram.sv
// Simple dual-port RAM with registered read port; storage is not reset.
`include "usb_defs.vh"

module usb_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = `CLOG2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    // rdata holds between reads so it doubles as the FIFO output register.
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/usb_packet_fifo.sv
// Packet FIFO with speculative write, commit/rollback and a registered read
// stage. Define USB_PACKET_FIFO_LAST_EN to carry rd_last through the RAM.
`include "usb_defs.vh"

module usb_packet_fifo
  import usb_packet_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic reset,
  usb_packet_fifo_if.slave bus
);

  localparam int AW = `CLOG2(DEPTH);
  localparam int RW = ram_width(WIDTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] cm_ptr_reg, cm_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0] level_reg, level_next;
  logic        ovf_reg, ovf_next;
  logic        dropped_reg, dropped_next;
  logic        valid_reg, valid_next;

  wr_op_e      wr_op;
  logic        full;
  logic        load;
  logic        ram_we;
  logic [RW-1:0] ram_wdata;
  logic [RW-1:0] ram_rdata;

  assign full = (wr_ptr_reg ^ rd_ptr_reg) == FULL_XOR;
  assign load = (!valid_reg || bus.rd_ready) && (cm_ptr_reg != rd_ptr_reg);

  always_comb begin
    wr_op = WR_NONE;
    if (bus.wr_abort) begin
      wr_op = WR_ABORT;
    end else if (bus.wr_strobe) begin
      if (bus.wr_last) begin
        wr_op = (ovf_reg || full) ? WR_DROP : WR_COMMIT;
      end else begin
        wr_op = full ? WR_OVERFLOW : WR_PUSH;
      end
    end
  end

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    cm_ptr_next  = cm_ptr_reg;
    ovf_next     = ovf_reg;
    dropped_next = 1'b0;
    rd_ptr_next  = load ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    case (wr_op)
      WR_PUSH:     wr_ptr_next = wr_ptr_reg + PTR_ONE;
      WR_OVERFLOW: ovf_next = 1'b1;
      WR_COMMIT: begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
        cm_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      WR_DROP: begin
        wr_ptr_next  = cm_ptr_reg;
        ovf_next     = 1'b0;
        dropped_next = 1'b1;
      end
      WR_ABORT: begin
        wr_ptr_next = cm_ptr_reg;
        ovf_next    = 1'b0;
      end
      default: ;
    endcase
    valid_next = load ? 1'b1 : (bus.rd_ready ? 1'b0 : valid_reg);
    // Committed-but-unread RAM entries plus the occupied output register.
    level_next = (cm_ptr_next - rd_ptr_next) + {{AW{1'b0}}, valid_next};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      cm_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      ovf_reg     <= 1'b0;
      dropped_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      cm_ptr_reg  <= cm_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      level_reg   <= level_next;
      ovf_reg     <= ovf_next;
      dropped_reg <= dropped_next;
      valid_reg   <= valid_next;
    end
  end

  assign ram_we = (wr_op == WR_PUSH) || (wr_op == WR_COMMIT);

`ifdef USB_PACKET_FIFO_LAST_EN
  assign ram_wdata   = {bus.wr_last, bus.wr_data};
  assign bus.rd_last = valid_reg & ram_rdata[WIDTH];
`else
  assign ram_wdata   = bus.wr_data;
  assign bus.rd_last = 1'b0;
`endif

  usb_fifo_ram #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (ram_wdata),
    .re    (load),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.rd_data     = ram_rdata[WIDTH-1:0];
  assign bus.rd_valid    = valid_reg;
  assign bus.wr_full     = full;
  assign bus.pkt_dropped = dropped_reg;
  assign bus.level       = level_reg;

endmodule

// File: tb/tb_usb_packet_fifo.sv
// Scoreboard bench for usb_packet_fifo: queue-based occupancy model drives
// per-cycle flag checks; a negedge monitor checks every delivered beat.
module tb_usb_packet_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  usb_packet_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  usb_packet_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  beat_t exp_q[$];   // committed beats not yet consumed, in delivery order
  beat_t spec_q[$];  // beats of the open packet that found room
  int    ram_cnt;    // committed beats still in RAM (not in output register)
  bit    m_ovf;
  bit    m_valid;
  int    vectors;
  int    miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    spec_q.delete();
    ram_cnt = 0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.wr_strobe = 1'b0;
    bus.wr_last   = 1'b0;
    bus.wr_abort  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_level", 32'(bus.level), 32'd0);
    check("reset_wr_full", 32'(bus.wr_full), 32'd0);
    check("reset_pkt_dropped", 32'(bus.pkt_dropped), 32'd0);
    check("reset_rd_last", 32'(bus.rd_last), 32'd0);
  endtask

  // One clock: drive inputs, advance the model, then check flags after the edge.
  task automatic step(input bit st, input bit la, input bit ab,
                      input logic [WIDTH-1:0] d, input bit rdy);
    bit full;
    bit load;
    bit drop;
    bus.wr_strobe = st;
    bus.wr_last   = la;
    bus.wr_abort  = ab;
    bus.wr_data   = d;
    bus.rd_ready  = rdy;
    full = (ram_cnt + spec_q.size()) == DEPTH;
    load = (!m_valid || rdy) && ram_cnt > 0;
    drop = 1'b0;
    if (load) ram_cnt--;
    if (ab) begin
      spec_q.delete();
      m_ovf = 1'b0;
    end else if (st) begin
      if (la) begin
        if (m_ovf || full) begin
          spec_q.delete();
          m_ovf = 1'b0;
          drop  = 1'b1;
        end else begin
          spec_q.push_back('{data: d, last: 1'b1});
          ram_cnt += spec_q.size();
          foreach (spec_q[i]) exp_q.push_back(spec_q[i]);
          spec_q.delete();
        end
      end else if (full) begin
        m_ovf = 1'b1;
      end else begin
        spec_q.push_back('{data: d, last: 1'b0});
      end
    end
    m_valid = load ? 1'b1 : (rdy ? 1'b0 : m_valid);
    @(posedge clk);
    #1;
    check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
    check("level", 32'(bus.level), 32'(ram_cnt + int'(m_valid)));
    check("wr_full", 32'(bus.wr_full), 32'((ram_cnt + spec_q.size()) == DEPTH));
    check("pkt_dropped", 32'(bus.pkt_dropped), 32'(drop));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, rdy);
  endtask

  // Monitor: the handshake seen at negedge completes at the following posedge.
  bit               stalled;
  logic [WIDTH-1:0] held_data;
  logic             held_last;
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled && bus.rd_valid) begin
        check("rd_data_hold", 32'(bus.rd_data), 32'(held_data));
        check("rd_last_hold", 32'(bus.rd_last), 32'(held_last));
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got %0h expected none", bus.rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 32'(bus.rd_data), 32'(e.data));
`ifdef USB_PACKET_FIFO_LAST_EN
          check("rd_last", 32'(bus.rd_last), 32'(e.last));
`else
          check("rd_last", 32'(bus.rd_last), 32'd0);
`endif
        end
      end
      stalled   = bus.rd_valid && !bus.rd_ready;
      held_data = bus.rd_data;
      held_last = bus.rd_last;
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    stalled     = 1'b0;
    do_reset();

    // Packet A0..A2 streamed straight through.
    step(1, 0, 0, 8'hA0, 1);
    step(1, 0, 0, 8'hA1, 1);
    step(1, 1, 0, 8'hA2, 1);
    idle(5, 1);

    // Aborted packet, then B0,B1 from the rolled-back address.
    step(1, 0, 0, 8'h11, 1);
    step(1, 0, 0, 8'h12, 1);
    step(0, 0, 1, 8'h00, 1);
    idle(2, 1);
    step(1, 0, 0, 8'hB0, 1);
    step(1, 1, 0, 8'hB1, 1);
    idle(4, 1);

    // Fill all entries with the reader stalled, then hit full with a 1-beat packet.
    step(1, 0, 0, 8'hC0, 0);
    step(1, 0, 0, 8'hC1, 0);
    step(1, 0, 0, 8'hC2, 0);
    step(1, 1, 0, 8'hC3, 0);
    step(1, 1, 0, 8'hCF, 0);
    idle(3, 0);
    idle(6, 1);

    // Committed data pending, then a packet that overflows mid-way.
    step(1, 0, 0, 8'hD0, 0);
    step(1, 1, 0, 8'hD1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'hE0 + 8'(i), 0);
    step(1, 1, 0, 8'hEF, 0);
    idle(6, 1);

    // Single-beat packets across pointer wrap with a random reader.
    for (int i = 0; i < 3 * DEPTH; i++) step(1, 1, 0, 8'(8'h40 + i), 1'($urandom_range(0, 1)));
    idle(8, 1);

    // Randomized mixed traffic.
    for (int i = 0; i < 400; i++) begin
      bit st;
      bit la;
      st = $urandom_range(0, 9) < 6;
      la = st && ($urandom_range(0, 3) == 0);
      step(st, la, $urandom_range(0, 24) == 0, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(8, 1);

    // Reset with committed data and an open packet, then a fresh packet.
    step(1, 0, 0, 8'h71, 0);
    step(1, 1, 0, 8'h72, 0);
    step(1, 0, 0, 8'h73, 0);
    do_reset();
    step(1, 0, 0, 8'h81, 1);
    step(1, 1, 0, 8'h82, 1);
    idle(6, 1);

    check("drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
